// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage: datapath width, the NOP
// encoding used for pipeline bubbles, the fetch FSM state type and a
// saturating increment used by the optional performance counters.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // ready to issue a request for PCF
    WAIT  = 2'd1,  // request outstanding, response will be used
    HOLD  = 2'd2,  // response parked in the skid buffer while decode stalls
    DROP  = 2'd3   // request outstanding, response will be discarded
  } fetch_state_e;

  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
    return (v == {XLEN{1'b1}}) ? v : v + XLEN'(1);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Bubble has priority over load; with neither asserted
// the register holds. A bubble replaces the instruction with NOP and clears the
// valid flag; the PC fields keep their previous values.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   load_i             capture instr_i / pc_i / pc_plus4_i as a valid entry
//   bubble_i           insert a bubble (NOP, valid=0)
//   instr_i, pc_i, pc_plus4_i   incoming fetch data
//   instr_o, pc_o, pc_plus4_o, valid_o   register contents
// -----------------------------------------------------------------------------
module if_id_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic            valid_q, valid_d;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (bubble_i) begin
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, issues one request at a time to the
// instruction memory, parks a response in a one-entry skid buffer when decode
// stalls, and squashes in-flight or buffered words on an execute redirect.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   StallF                   hold PC, issue no new request
//   StallD                   hold the IF/ID register
//   PCSrcE, PCTargetE        redirect from execute (target word-aligned here)
//   imem_req, imem_addr      one-cycle request pulse and its address (PCF)
//   imem_ack, imem_rdata     response strobe and instruction word
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register contents
//   FetchBusy                FSM is not in FETCH
//   StallCount, FlushCount   (only with FETCH_PERF_CNT_EN) saturating counters
//
// Build option: define FETCH_PERF_CNT_EN to add the performance counters.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchBusy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] StallCount,
  output logic [XLEN-1:0] FlushCount
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] skid_q, skid_d;
  logic [XLEN-1:0] pc_plus4;
  logic            req_raw;
  logic            id_load, id_bubble;
  logic [XLEN-1:0] id_instr;
  logic            tgt_lsb_unused;

  // Redirect targets are forced to word alignment, so the low bits are dropped.
  assign tgt_lsb_unused = ^PCTargetE[1:0];

  // Wraps naturally modulo 2^XLEN.
  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    skid_d    = skid_q;
    req_raw   = 1'b0;
    id_load   = 1'b0;
    id_bubble = 1'b0;
    id_instr  = NOP;

    if (PCSrcE) begin
      // Redirect wins over everything, including a decode stall.
      pc_d      = {PCTargetE[XLEN-1:2], 2'b00};
      id_bubble = 1'b1;
      // A request still in flight must have its response swallowed.
      if ((state_q == WAIT || state_q == DROP) && !imem_ack) begin
        state_d = DROP;
      end else begin
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          // imem_ack here is spurious and deliberately ignored.
          if (!StallF) begin
            req_raw = 1'b1;
            state_d = WAIT;
          end
          id_bubble = !StallD;
        end
        WAIT: begin
          if (imem_ack) begin
            if (StallD) begin
              skid_d  = imem_rdata;
              state_d = HOLD;
            end else begin
              id_load  = 1'b1;
              id_instr = imem_rdata;
              pc_d     = pc_plus4;
              state_d  = FETCH;
            end
          end else begin
            id_bubble = !StallD;
          end
        end
        HOLD: begin
          if (!StallD) begin
            id_load  = 1'b1;
            id_instr = skid_q;
            pc_d     = pc_plus4;
            state_d  = FETCH;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_d = FETCH;
          end
          id_bubble = !StallD;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
    end
  end

  // The state register sits in FETCH during reset; gating keeps the request
  // line quiet until reset is released.
  assign imem_req  = req_raw & rst;
  assign imem_addr = pc_q;
  assign FetchBusy = (state_q != FETCH);

  if_id_reg u_if_id (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (id_load),
    .bubble_i   (id_bubble),
    .instr_i    (id_instr),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .instr_o    (InstrD),
    .pc_o       (PCD),
    .pc_plus4_o (PCPlus4D),
    .valid_o    (ValidD)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = (StallD && ValidD) ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = PCSrcE ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A behavioural model tracks the fetch
// stage as "request outstanding / response to be discarded / word parked"
// flags plus the IF/ID contents; a memory responder answers each request after
// a configurable delay. A second instance checks PC wrap from RESET_PC.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EXP_NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall_f, stall_d, pcsrc_e, imem_ack;
  logic [31:0] pctarget_e, imem_rdata;
  logic        imem_req, valid_d, fetch_busy;
  logic [31:0] imem_addr, instr_d, pc_d, pcplus4_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
`endif

  fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk(clk), .rst(rst), .StallF(stall_f), .StallD(stall_d),
    .PCSrcE(pcsrc_e), .PCTargetE(pctarget_e),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .InstrD(instr_d), .PCD(pc_d), .PCPlus4D(pcplus4_d),
    .ValidD(valid_d), .FetchBusy(fetch_busy)
`ifdef FETCH_PERF_CNT_EN
    , .StallCount(stall_count), .FlushCount(flush_count)
`endif
  );

  // Second instance for the wrap-around case.
  logic        rst2, b_ack, b_req, b_valid, b_busy;
  logic [31:0] b_rdata, b_addr, b_instr, b_pcd, b_pcp4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] b_stall_count, b_flush_count;
`endif

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .StallF(1'b0), .StallD(1'b0),
    .PCSrcE(1'b0), .PCTargetE(32'h0),
    .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(b_ack), .imem_rdata(b_rdata),
    .InstrD(b_instr), .PCD(b_pcd), .PCPlus4D(b_pcp4),
    .ValidD(b_valid), .FetchBusy(b_busy)
`ifdef FETCH_PERF_CNT_EN
    , .StallCount(b_stall_count), .FlushCount(b_flush_count)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pcd, m_pcp4, m_buf;
  logic        m_valid, m_out, m_drop, m_buf_v;
  logic [31:0] m_stall, m_flush;

  // Memory responder state.
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          mem_lo = 1, mem_hi = 1;
  bit          mem_fixed = 1'b0;
  logic [31:0] mem_fixed_data = 32'h0;
  int          spur_pct = 0;
  bit          force_ack = 1'b0;
  logic [31:0] req_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_fixed ? mem_fixed_data : (a ^ 32'h5A5A_3C3C) + 32'h0000_1111;
  endfunction

  task automatic model_reset();
    m_pc = TB_RESET_PC; m_instr = EXP_NOP; m_pcd = '0; m_pcp4 = '0;
    m_buf = '0; m_valid = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_buf_v = 1'b0;
    m_stall = '0; m_flush = '0;
  endtask

  // One cycle of architectural behaviour, stated as data movement.
  task automatic model_step(input logic sf, input logic sd, input logic br,
                            input logic [31:0] tgt, input logic ack,
                            input logic [31:0] rd);
    logic        issue, have;
    logic [31:0] word;
    issue = !m_out && !m_buf_v && !sf && !br;
    if (sd && m_valid && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (br && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
    if (br) begin
      m_pc = {tgt[31:2], 2'b00};
      m_instr = EXP_NOP; m_valid = 1'b0; m_buf_v = 1'b0;
      if (m_out && !ack) m_drop = 1'b1;
      else begin m_out = 1'b0; m_drop = 1'b0; end
    end else begin
      have = 1'b0; word = '0;
      if (m_buf_v) begin
        have = 1'b1; word = m_buf;
      end else if (m_out && ack) begin
        if (!m_drop) begin have = 1'b1; word = rd; end
        m_out = 1'b0; m_drop = 1'b0;
      end
      if (have && !sd) begin
        m_instr = word; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_buf_v = 1'b0;
      end else if (have) begin
        m_buf_v = 1'b1; m_buf = word;
      end else if (!sd) begin
        m_instr = EXP_NOP; m_valid = 1'b0;
      end
      if (issue) m_out = 1'b1;
    end
  endtask

  // Drives one cycle (entered at posedge+1), compares at negedge, steps model.
  task automatic run_cycle(input logic sf, input logic sd, input logic br,
                           input logic [31:0] tgt);
    logic exp_req;
    stall_f = sf; stall_d = sd; pcsrc_e = br; pctarget_e = tgt;
    imem_ack = 1'b0; imem_rdata = $urandom;
    if (mem_busy) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        imem_ack = 1'b1; imem_rdata = mem_word(mem_addr); mem_busy = 1'b0;
      end
    end else if (force_ack || ($urandom_range(0, 99) < spur_pct)) begin
      imem_ack = 1'b1;
    end
    force_ack = 1'b0;
    @(negedge clk);
    exp_req = !m_out && !m_buf_v && !sf && !br;
    total++; if (imem_req !== exp_req) begin bad++; $display("FAIL imem_req cyc=%0d got=%b want=%b", cyc, imem_req, exp_req); end
    total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, imem_addr, m_pc); end
    total++; if (instr_d !== m_instr) begin bad++; $display("FAIL InstrD cyc=%0d got=%h want=%h", cyc, instr_d, m_instr); end
    total++; if (valid_d !== m_valid) begin bad++; $display("FAIL ValidD cyc=%0d got=%b want=%b", cyc, valid_d, m_valid); end
    total++; if (fetch_busy !== (m_out || m_buf_v)) begin bad++; $display("FAIL FetchBusy cyc=%0d got=%b want=%b", cyc, fetch_busy, m_out || m_buf_v); end
    if (m_valid) begin
      total++; if (pc_d !== m_pcd) begin bad++; $display("FAIL PCD cyc=%0d got=%h want=%h", cyc, pc_d, m_pcd); end
      total++; if (pcplus4_d !== m_pcp4) begin bad++; $display("FAIL PCPlus4D cyc=%0d got=%h want=%h", cyc, pcplus4_d, m_pcp4); end
    end
`ifdef FETCH_PERF_CNT_EN
    total++; if (stall_count !== m_stall) begin bad++; $display("FAIL StallCount cyc=%0d got=%0d want=%0d", cyc, stall_count, m_stall); end
    total++; if (flush_count !== m_flush) begin bad++; $display("FAIL FlushCount cyc=%0d got=%0d want=%0d", cyc, flush_count, m_flush); end
`endif
    if (imem_req === 1'b1) begin
      mem_busy = 1'b1; mem_cnt = $urandom_range(mem_lo, mem_hi);
      mem_addr = imem_addr; req_log.push_back(imem_addr);
    end
    model_step(sf, sd, br, tgt, imem_ack, imem_rdata);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic apply_reset();
    @(posedge clk); #3;
    rst = 1'b0;
    stall_f = 1'b0; stall_d = 1'b0; pcsrc_e = 1'b0; imem_ack = 1'b0;
    model_reset(); mem_busy = 1'b0; force_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
    total++; if (imem_addr !== TB_RESET_PC) begin bad++; $display("FAIL rst_addr got=%h want=%h", imem_addr, TB_RESET_PC); end
    total++; if (instr_d !== EXP_NOP) begin bad++; $display("FAIL rst_instr got=%h want=%h", instr_d, EXP_NOP); end
    total++; if (pc_d !== 32'h0) begin bad++; $display("FAIL rst_pcd got=%h want=0", pc_d); end
    total++; if (pcplus4_d !== 32'h0) begin bad++; $display("FAIL rst_pcp4 got=%h want=0", pcplus4_d); end
    total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", valid_d); end
    total++; if (fetch_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", fetch_busy); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (stall_count !== 32'h0 || flush_count !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", stall_count, flush_count); end
`endif
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_basic();
    mem_fixed = 1'b1; mem_fixed_data = 32'h0050_0093; mem_lo = 1; mem_hi = 1;
    spur_pct = 0; req_log.delete();
    run_cycle(0, 0, 0, 0); run_cycle(0, 0, 0, 0);
    total++; if (valid_d !== 1'b1 || pc_d !== 32'h0 || instr_d !== 32'h0050_0093) begin
      bad++; $display("FAIL basic_first got=v%b pc=%h i=%h want=v1 pc=0 i=00500093", valid_d, pc_d, instr_d); end
    run_cycle(0, 0, 0, 0); run_cycle(0, 0, 0, 0);
    total++; if (pc_d !== 32'h4 || pcplus4_d !== 32'h8) begin
      bad++; $display("FAIL basic_second got=pc=%h p4=%h want=pc=4 p4=8", pc_d, pcplus4_d); end
    run_cycle(0, 0, 0, 0);
    total++; if (req_log.size() != 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8) begin
      bad++; $display("FAIL basic_reqs got=%0d reqs want=0,4,8", req_log.size()); end
  endtask

  task automatic test_skid();
    run_cycle(0, 1, 0, 0);
    total++; if (fetch_busy !== 1'b1 || pc_d !== 32'h4) begin
      bad++; $display("FAIL skid_hold got=busy%b pc=%h want=busy1 pc=4", fetch_busy, pc_d); end
    run_cycle(0, 1, 0, 0);
    total++; if (pc_d !== 32'h4) begin bad++; $display("FAIL skid_hold2 got=%h want=4", pc_d); end
    run_cycle(0, 0, 0, 0);
    total++; if (pc_d !== 32'h8 || valid_d !== 1'b1 || pcplus4_d !== 32'hC) begin
      bad++; $display("FAIL skid_release got=pc=%h v=%b want=pc=8 v=1", pc_d, valid_d); end
    run_cycle(0, 0, 0, 0);
    total++; if (req_log[req_log.size()-1] !== 32'hC) begin
      bad++; $display("FAIL skid_next_req got=%h want=c", req_log[req_log.size()-1]); end
  endtask

  task automatic test_redirect();
    run_cycle(0, 0, 0, 0);
    mem_lo = 2; mem_hi = 2;
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 1, 32'h0000_0103);
    total++; if (valid_d !== 1'b0 || fetch_busy !== 1'b1) begin
      bad++; $display("FAIL redir_drop got=v%b busy%b want=v0 busy1", valid_d, fetch_busy); end
    run_cycle(0, 0, 0, 0);
    total++; if (valid_d !== 1'b0 || fetch_busy !== 1'b0) begin
      bad++; $display("FAIL redir_discard got=v%b busy%b want=v0 busy0", valid_d, fetch_busy); end
    run_cycle(0, 0, 0, 0);
    total++; if (req_log[req_log.size()-1] !== 32'h0000_0100) begin
      bad++; $display("FAIL redir_req got=%h want=100", req_log[req_log.size()-1]); end
  endtask

  task automatic test_fetch_ack_ignored();
    apply_reset();
    mem_lo = 1; mem_hi = 1;
    force_ack = 1'b1;
    run_cycle(1, 0, 0, 0);
    total++; if (valid_d !== 1'b0 || fetch_busy !== 1'b0) begin
      bad++; $display("FAIL ack_in_fetch got=v%b busy%b want=v0 busy0", valid_d, fetch_busy); end
    req_log.delete();
    run_cycle(0, 0, 0, 0);
    total++; if (req_log.size() != 1 || req_log[0] !== TB_RESET_PC) begin
      bad++; $display("FAIL ack_in_fetch_pc got=%0d reqs want=1 at %h", req_log.size(), TB_RESET_PC); end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    mem_lo = 3; mem_hi = 3;
    run_cycle(0, 0, 1, 32'h0000_0040);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 0);
    #3 rst = 1'b0;
    #1;
    total++; if (fetch_busy !== 1'b0 || imem_req !== 1'b0 || imem_addr !== TB_RESET_PC || valid_d !== 1'b0) begin
      bad++; $display("FAIL mid_wait_reset got=busy%b req%b addr=%h want=busy0 req0 addr=%h", fetch_busy, imem_req, imem_addr, TB_RESET_PC); end
    model_reset(); mem_busy = 1'b0; imem_ack = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    req_log.delete();
    run_cycle(0, 0, 0, 0);
    total++; if (req_log.size() != 1 || req_log[0] !== TB_RESET_PC) begin
      bad++; $display("FAIL mid_wait_first_req got=%0d reqs want=1 at %h", req_log.size(), TB_RESET_PC); end
  endtask

  task automatic test_wrap();
    @(posedge clk); #1 rst2 = 1'b1;
    @(negedge clk);
    total++; if (b_req !== 1'b1 || b_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_first got=req%b addr=%h want=req1 addr=fffffffc", b_req, b_addr); end
    @(posedge clk); #1 b_ack = 1'b1; b_rdata = 32'h1234_5678;
    @(posedge clk); #1 b_ack = 1'b0;
    @(negedge clk);
    total++; if (b_req !== 1'b1 || b_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_next got=req%b addr=%h want=req1 addr=0", b_req, b_addr); end
    total++; if (b_pcd !== 32'hFFFF_FFFC || b_pcp4 !== 32'h0 || b_valid !== 1'b1 || b_instr !== 32'h1234_5678) begin
      bad++; $display("FAIL wrap_ifid got=pc=%h p4=%h v=%b i=%h want=pc=fffffffc p4=0 v=1 i=12345678", b_pcd, b_pcp4, b_valid, b_instr); end
  endtask

  task automatic test_random();
    mem_fixed = 1'b0; mem_lo = 1; mem_hi = 3; spur_pct = 10;
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset();
      for (int i = 0; i < 1500; i++) begin
        run_cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 10, $urandom);
      end
    end
    spur_pct = 0;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    apply_reset();
    mem_lo = 1; mem_hi = 1;
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 0);
    run_cycle(1, 1, 0, 0); run_cycle(1, 1, 0, 0); run_cycle(1, 1, 0, 0);
    run_cycle(1, 0, 1, 32'h0000_0200); run_cycle(1, 0, 1, 32'h0000_0300);
    total++; if (stall_count !== 32'd3) begin bad++; $display("FAIL perf_stall got=%0d want=3", stall_count); end
    total++; if (flush_count !== 32'd2) begin bad++; $display("FAIL perf_flush got=%0d want=2", flush_count); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; rst2 = 1'b0;
    stall_f = 1'b0; stall_d = 1'b0; pcsrc_e = 1'b0; pctarget_e = '0;
    imem_ack = 1'b0; imem_rdata = '0; b_ack = 1'b0; b_rdata = '0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
    test_reset();
    test_basic();
    test_skid();
    test_redirect();
    test_fetch_ack_ignored();
    test_reset_mid_wait();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the PC loaded on reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 StallF  input  1  hold PC; no new fetch request.
REQ-005 StallD  input  1  hold IF/ID register contents.
REQ-006 PCSrcE  input  1  taken branch/jump redirect from execute.
REQ-007 PCTargetE  input  32  redirect address.
REQ-008 imem_req  output  1  one-cycle request pulse.
REQ-009 imem_addr  output  32  request address (current PCF).
REQ-010 imem_ack  input  1  response valid; at least 1 cycle after imem_req.
REQ-011 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-012 InstrD, PCD, PCPlus4D  output  32 each  IF/ID register contents.
REQ-013 ValidD  output  1  IF/ID holds a real instruction, not a bubble.
REQ-014 FetchBusy  output  1  state is not FETCH.

Function
REQ-015 FSM states: FETCH, WAIT, HOLD, DROP.
REQ-016 FETCH, StallF=0, PCSrcE=0: imem_req=1, imem_addr=PCF, next WAIT; with StallF=1: imem_req=0, stay FETCH.
REQ-017 WAIT, imem_ack=1, StallD=0: IF/ID <= {imem_rdata, PCF, PCF+4}, ValidD<=1, PCF<=PCF+4, next FETCH.
REQ-018 WAIT, imem_ack=1, StallD=1: word goes to skid buffer, next HOLD; PCF unchanged.
REQ-019 HOLD, StallD falls: skid buffer loads IF/ID, ValidD<=1, PCF<=PCF+4, next FETCH.
REQ-020 Any cycle with StallD=0 and no instruction loaded: IF/ID loads bubble (InstrD=NOP 32'h0000_0013, ValidD=0).
REQ-021 StallD=1, no flush: IF/ID holds all values.
REQ-022 PCSrcE=1 in any state: PCF<={PCTargetE[31:2],2'b00}; IF/ID loads bubble (flush beats StallD); imem_req=0 that cycle.
REQ-023 Redirect in WAIT without ack: next DROP; in WAIT with same-cycle ack, HOLD, or FETCH: word/buffer discarded, next FETCH.
REQ-024 DROP: discard response on imem_ack, next FETCH; a redirect in DROP updates PCF, stays DROP.
REQ-025 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-026 imem_ack in FETCH state is ignored.

Reset
REQ-027 rst=0 asynchronously: PCF=RESET_PC, state FETCH, imem_req=0, InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0, skid buffer cleared, counters 0.
REQ-028 Reset mid-WAIT abandons the outstanding request; first post-reset request goes to RESET_PC.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: outputs StallCount[31:0] (cycles with StallD=1 and ValidD=1) and FlushCount[31:0] (cycles with PCSrcE=1), both saturating at 32'hFFFF_FFFF.
REQ-030 FETCH_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-031 Package fetch_pkg holds NOP constant, FSM state enum, XLEN=32.
REQ-032 Sub-module if_id_reg implements IF/ID register with load/hold/bubble controls; FSM, PC, and skid buffer stay in fetch_unit.

Verification
REQ-033 Reset release, ack 1 cycle after each req, rdata=32'h00500093: requests to 0,4,8; ValidD=1 with PCD=0 then 4.
REQ-034 StallD=1 on ack of PC=8: state HOLD, InstrD unchanged; StallD=0 two cycles later -> PCD=8, next req addr 12.
REQ-035 PCSrcE=1, PCTargetE=32'h0000_0103 during WAIT: ack discarded, ValidD=0, next req addr 32'h0000_0100.
REQ-036 RESET_PC=32'hFFFF_FFFC: after first fetch, next req addr 32'h0000_0000.
REQ-037 FETCH_PERF_CNT_EN defined, 3 stalled cycles with ValidD=1 and 2 redirects: StallCount=3, FlushCount=2.
